// File: rtl/fp32_accum.sv
// Iterative fp32 accumulator: IDLE -> ALIGN -> ADD -> NORM -> ROUND, one element per five cycles.
// Optional FP32_ACCUM_SAT_EN: overflow saturates to max finite instead of producing inf.
module fp32_accum #(
    parameter int COUNT_W = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    input  logic               last_in,
    input  logic [31:0]        a_in,
    output logic               ready_out,
    output logic               valid_out,
    output logic [31:0]        sum_out,
    output logic [COUNT_W-1:0] count_out
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [31:0] QNAN   = 32'h7FC00000;

    logic [2:0]         state;
    logic [31:0]        acc;
    logic [31:0]        elem;
    logic               last_r;
    logic [COUNT_W-1:0] cnt;

    // Stage registers
    logic        al_sign, al_sub, spec_r;
    logic [31:0] spec_val;
    logic [7:0]  al_exp;
    logic [23:0] al_mx;
    logic [26:0] al_my;
    logic        ad_sign;
    logic [7:0]  ad_exp;
    logic [27:0] ad_sum;
    logic        nm_sign, nm_zero;
    logic [9:0]  nm_exp;
    logic [26:0] nm_mant;

    assign ready_out = (state == S_IDLE);

    // ALIGN combinational
    logic        a_nan, b_nan, a_inf, b_inf, swap;
    logic [31:0] fa, fb, x, y;
    logic [23:0] mx, my;
    logic [7:0]  d;
    logic [53:0] ext;
    logic [26:0] my_sh;
    logic        c_spec;
    logic [31:0] c_spec_val;

    always_comb begin
        a_nan = (acc[30:23] == 8'hFF) && (acc[22:0] != '0);
        b_nan = (elem[30:23] == 8'hFF) && (elem[22:0] != '0);
        a_inf = (acc[30:23] == 8'hFF) && (acc[22:0] == '0);
        b_inf = (elem[30:23] == 8'hFF) && (elem[22:0] == '0);
        fa = (acc[30:23] == '0) ? {acc[31], 31'b0} : acc;
        fb = (elem[30:23] == '0) ? {elem[31], 31'b0} : elem;
        swap = fb[30:0] > fa[30:0];
        x = swap ? fb : fa;
        y = swap ? fa : fb;
        mx = (x[30:23] == '0) ? '0 : {1'b1, x[22:0]};
        my = (y[30:23] == '0) ? '0 : {1'b1, y[22:0]};
        d = x[30:23] - y[30:23];
        ext = '0;
        if (d >= 8'd26) begin
            my_sh = {26'b0, |my};
        end else begin
            ext = {my, 3'b0, 27'b0} >> d[4:0];
            my_sh = {ext[53:28], ext[27] | (|ext[26:0])};
        end
        c_spec = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (acc[31] != elem[31])))
            c_spec_val = QNAN;
        else if (a_inf)
            c_spec_val = acc;
        else
            c_spec_val = elem;
    end

    // NORM combinational: priority encoder for the leading one
    logic [4:0]  lz;
    logic        n_zero, n_sign;
    logic [9:0]  n_exp;
    logic [26:0] n_mant;

    always_comb begin
        lz = 5'd27;
        for (int unsigned i = 0; i < 27; i++)
            if (ad_sum[i]) lz = 5'(26 - i);
        n_zero = 1'b0;
        n_sign = ad_sign;
        n_exp  = {2'b0, ad_exp};
        n_mant = ad_sum[26:0];
        if (ad_sum[27]) begin
            n_mant = {ad_sum[27:2], ad_sum[1] | ad_sum[0]};
            n_exp  = {2'b0, ad_exp} + 10'd1;
        end else if (ad_sum == '0) begin
            n_zero = 1'b1;
            n_sign = 1'b0;
        end else if ({2'b0, ad_exp} <= {5'b0, lz}) begin
            n_zero = 1'b1;
        end else begin
            n_mant = ad_sum[26:0] << lz;
            n_exp  = {2'b0, ad_exp} - {5'b0, lz};
        end
    end

    // ROUND combinational: nearest-even on guard/round/sticky
    logic        up;
    logic [24:0] m25;
    logic [9:0]  r_exp;
    logic [31:0] result;

    always_comb begin
        up = nm_mant[2] & (nm_mant[1] | nm_mant[0] | nm_mant[3]);
        m25 = {1'b0, nm_mant[26:3]} + {24'b0, up};
        r_exp = m25[24] ? nm_exp + 10'd1 : nm_exp;
        if (spec_r)
            result = spec_val;
        else if (nm_zero)
            result = {nm_sign, 31'b0};
        else if (r_exp >= 10'd255)
`ifdef FP32_ACCUM_SAT_EN
            result = {nm_sign, 31'h7F7FFFFF};
`else
            result = {nm_sign, 31'h7F800000};
`endif
        else
            result = {nm_sign, r_exp[7:0], m25[24] ? m25[23:1] : m25[22:0]};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            acc       <= '0;
            elem      <= '0;
            last_r    <= 1'b0;
            cnt       <= '0;
            valid_out <= 1'b0;
            sum_out   <= '0;
            count_out <= '0;
            al_sign   <= 1'b0;
            al_sub    <= 1'b0;
            spec_r    <= 1'b0;
            spec_val  <= '0;
            al_exp    <= '0;
            al_mx     <= '0;
            al_my     <= '0;
            ad_sign   <= 1'b0;
            ad_exp    <= '0;
            ad_sum    <= '0;
            nm_sign   <= 1'b0;
            nm_zero   <= 1'b0;
            nm_exp    <= '0;
            nm_mant   <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: if (valid_in) begin
                    elem   <= a_in;
                    last_r <= last_in;
                    state  <= S_ALIGN;
                end
                S_ALIGN: begin
                    al_sign  <= x[31];
                    al_sub   <= x[31] ^ y[31];
                    al_exp   <= x[30:23];
                    al_mx    <= mx;
                    al_my    <= my_sh;
                    spec_r   <= c_spec;
                    spec_val <= c_spec_val;
                    state    <= S_ADD;
                end
                S_ADD: begin
                    ad_sign <= al_sign;
                    ad_exp  <= al_exp;
                    ad_sum  <= al_sub ? {1'b0, al_mx, 3'b0} - {1'b0, al_my}
                                      : {1'b0, al_mx, 3'b0} + {1'b0, al_my};
                    state   <= S_NORM;
                end
                S_NORM: begin
                    nm_sign <= n_sign;
                    nm_zero <= n_zero;
                    nm_exp  <= n_exp;
                    nm_mant <= n_mant;
                    state   <= S_ROUND;
                end
                S_ROUND: begin
                    if (last_r) begin
                        sum_out   <= result;
                        count_out <= cnt + 1'b1;
                        valid_out <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                    end else begin
                        acc <= result;
                        cnt <= cnt + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_accum.sv
// Directed-vector bench for fp32_accum with hand-computed expected sums and counts.
module tb_fp32_accum;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic        last_in;
    logic [31:0] a_in;
    logic        ready_out;
    logic        valid_out;
    logic [31:0] sum_out;
    logic [15:0] count_out;

    int checks = 0;
    int errors = 0;

    fp32_accum #(.COUNT_W(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .last_in(last_in),
        .a_in(a_in), .ready_out(ready_out), .valid_out(valid_out),
        .sum_out(sum_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one element once ready_out is seen; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic last);
        int waited = 0;
        while (!ready_out && waited < 20) begin
            @(posedge clk_in); #1;
            waited++;
        end
        if (!ready_out) check_eq("send_ready_timeout", 32'd0, 32'd1);
        valid_in = 1'b1;
        a_in = a;
        last_in = last;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        last_in = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] sum, input logic [31:0] cnt);
        int waited = 0;
        while (!valid_out && waited < 12) begin
            @(posedge clk_in); #1;
            waited++;
        end
        check_eq({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
        check_eq({tag, "_sum"}, sum_out, sum);
        check_eq({tag, "_count"}, {16'b0, count_out}, cnt);
        @(posedge clk_in); #1;
        check_eq({tag, "_pulse"}, {31'b0, valid_out}, 32'd0);
    endtask

    task automatic pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sum);
        send(a, 1'b0);
        send(b, 1'b1);
        expect_result(tag, sum, 32'd2);
    endtask

    initial begin
        int accepts;
        int low;
        rst_in = 1'b1;
        valid_in = 1'b0;
        last_in = 1'b0;
        a_in = '0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_eq("rst_ready", {31'b0, ready_out}, 32'd1);
        check_eq("rst_valid", {31'b0, valid_out}, 32'd0);
        check_eq("rst_sum", sum_out, 32'd0);
        check_eq("rst_count", {16'b0, count_out}, 32'd0);

        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h3F000000, 1'b1);
        expect_result("sum3", 32'h40600000, 32'd3);

        pair("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000);
        pair("tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000);
        pair("tie_up", 32'h3F800000, 32'h33C00000, 32'h3F800001);
        pair("sub_sticky", 32'h3F800000, 32'hB0800000, 32'h3F800000);
        pair("sub3m1", 32'h40400000, 32'hBF800000, 32'h40000000);
`ifdef FP32_ACCUM_SAT_EN
        pair("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF);
`else
        pair("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
`endif
        pair("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        pair("nan_prop", 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        pair("inf_plus_one", 32'hFF800000, 32'h3F800000, 32'hFF800000);

        send(32'h80000000, 1'b1);
        expect_result("neg_zero", 32'h00000000, 32'd1);
        send(32'h00400000, 1'b1);
        expect_result("denorm", 32'h00000000, 32'd1);
        send(32'hBFC00000, 1'b1);
        expect_result("single", 32'hBFC00000, 32'd1);

        // Reset while the element sits in NORM
        send(32'h3F800000, 1'b1);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check_eq("midrst_ready", {31'b0, ready_out}, 32'd1);
        check_eq("midrst_valid", {31'b0, valid_out}, 32'd0);
        check_eq("midrst_sum", sum_out, 32'd0);
        send(32'h40000000, 1'b1);
        expect_result("after_rst", 32'h40000000, 32'd1);

        // Continuous valid_in: one accept per five cycles
        accepts = 0;
        low = 0;
        valid_in = 1'b1;
        last_in = 1'b1;
        a_in = 32'h3F800000;
        for (int i = 0; i < 25; i++) begin
            if (ready_out) accepts++;
            else low++;
            @(posedge clk_in); #1;
        end
        valid_in = 1'b0;
        last_in = 1'b0;
        check_eq("stream_accepts", accepts, 32'd5);
        check_eq("stream_ready_low", low, 32'd20);
        repeat (8) @(posedge clk_in);
        #1;
        check_eq("stream_sum", sum_out, 32'h3F800000);
        check_eq("stream_count", {16'b0, count_out}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
